// File: rtl/microseq_pkg.sv
// Shared definitions for the microsequencer: default widths, microinstruction
// field offsets and the named bus select codes used by microcode authors.
package microseq_pkg;

    localparam int DEF_OP_W      = 8;
    localparam int DEF_STEP_W    = 3;
    localparam int DEF_OUT_SEL_W = 3;
    localparam int DEF_IN_SEL_W  = 3;
    localparam int DEF_ALU_W     = 6;
    localparam int DEF_UI_W      = 16;

    // Offsets of the fields that move with UI_W / OUT_SEL_W.
    function automatic int eo_bit_of(input int ui_w);
        return ui_w - 1;
    endfunction

    function automatic int out_sel_lsb_of(input int ui_w, input int out_sel_w);
        return ui_w - 1 - out_sel_w;
    endfunction

    function automatic int rt_bit_of(input int ui_w, input int out_sel_w);
        return ui_w - 2 - out_sel_w;
    endfunction

    function automatic int pp_bit_of(input int ui_w, input int out_sel_w);
        return ui_w - 3 - out_sel_w;
    endfunction

    localparam int EO_BIT      = eo_bit_of(DEF_UI_W);
    localparam int OUT_SEL_LSB = out_sel_lsb_of(DEF_UI_W, DEF_OUT_SEL_W);
    localparam int RT_BIT      = rt_bit_of(DEF_UI_W, DEF_OUT_SEL_W);
    localparam int PP_BIT      = pp_bit_of(DEF_UI_W, DEF_OUT_SEL_W);
    localparam int IN_SEL_LSB  = 5;
    localparam int JZ_BIT      = 4;
    localparam int JGT_BIT     = 3;
    localparam int JLT_BIT     = 2;

    typedef enum logic [DEF_OUT_SEL_W-1:0] {
        OUT_PC  = 3'd0,
        OUT_IRH = 3'd1,
        OUT_IRL = 3'd2,
        OUT_MEM = 3'd3,
        OUT_DEV = 3'd6
    } out_sel_e;

    typedef enum logic [DEF_IN_SEL_W-1:0] {
        IN_NONE = 3'd0,
        IN_ADDR = 3'd1,
        IN_IR   = 3'd2,
        IN_MEM  = 3'd3,
        IN_X    = 3'd4,
        IN_Y    = 3'd5,
        IN_DEV  = 3'd6
    } in_sel_e;

endpackage

// File: rtl/onehot_dec.sv
// N-to-2^N one-hot decoder with an enable; all outputs low when disabled.
module onehot_dec #(
    parameter int N = 3
) (
    input  logic [N-1:0]      sel,
    input  logic              en,
    output logic [(1<<N)-1:0] y
);

    always_comb begin
        y = '0;
        if (en) y[sel] = 1'b1;
    end

endmodule

// File: rtl/microseq_ctrl.sv
// Microsequencer and control decoder: steps through {opcode, step} ROM
// addresses and turns each microinstruction into datapath strobes.
module microseq_ctrl
    import microseq_pkg::*;
#(
    parameter int OP_W      = DEF_OP_W,
    parameter int STEP_W    = DEF_STEP_W,
    parameter int OUT_SEL_W = DEF_OUT_SEL_W,
    parameter int IN_SEL_W  = DEF_IN_SEL_W,
    parameter int ALU_W     = DEF_ALU_W,
    parameter int UI_W      = DEF_UI_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [OP_W-1:0]           opcode,
    output logic [OP_W+STEP_W-1:0]    uaddr,
    input  logic [UI_W-1:0]           uinstr,
    input  logic                      alu_z,
    input  logic                      alu_lt,
    input  logic                      stall,
    output logic                      eo,
    output logic [ALU_W-1:0]          alu_flags,
    output logic [(1<<OUT_SEL_W)-1:0] out_en,
    output logic [(1<<IN_SEL_W)-1:0]  in_en,
    output logic                      pc_inc,
    output logic                      pc_load,
    output logic [STEP_W-1:0]         step,
    output logic                      ins_start
);

    localparam int EO_B   = eo_bit_of(UI_W);
    localparam int OS_LSB = out_sel_lsb_of(UI_W, OUT_SEL_W);
    localparam int RT_B   = rt_bit_of(UI_W, OUT_SEL_W);
    localparam int PP_B   = pp_bit_of(UI_W, OUT_SEL_W);
    localparam logic [STEP_W-1:0] STEP_LAST = '1;

    logic                 fz;
    logic                 flt;
    logic                 rt;
    logic                 pp;
    logic                 jmp;
    logic                 wr_ok;
    logic [OUT_SEL_W-1:0] out_sel;
    logic [IN_SEL_W-1:0]  in_sel;
    logic                 unused_bits;

    // Reserved bits and gap bits are deliberately ignored.
    assign unused_bits = ^uinstr;

    assign eo        = ~uinstr[EO_B];
    assign alu_flags = uinstr[UI_W-2 -: ALU_W];
    assign out_sel   = uinstr[OS_LSB +: OUT_SEL_W];
    assign rt        = ~eo & uinstr[RT_B];
    assign pp        = ~eo & uinstr[PP_B];
    assign in_sel    = uinstr[IN_SEL_LSB +: IN_SEL_W];

    // Writes and PC updates are blocked while a device stalls or during reset;
    // bus-out strobes stay driven so the bus value remains stable.
    assign wr_ok   = ~stall & ~reset;
    assign jmp     = (uinstr[JZ_BIT] & fz) | (uinstr[JLT_BIT] & flt)
                   | (uinstr[JGT_BIT] & ~fz & ~flt);
    assign pc_inc  = pp & wr_ok;
    assign pc_load = jmp & wr_ok;

    onehot_dec #(.N(OUT_SEL_W)) u_out_dec (
        .sel (out_sel),
        .en  (~eo),
        .y   (out_en)
    );

    onehot_dec #(.N(IN_SEL_W)) u_in_dec (
        .sel (in_sel),
        .en  (wr_ok & (in_sel != '0)),
        .y   (in_en)
    );

    assign uaddr     = {opcode, step};
    assign ins_start = (step == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            step <= '0;
        end else if (!stall) begin
            if (rt || step == STEP_LAST) step <= '0;
            else                         step <= step + 1'b1;
        end
    end

    // Flags are registered, so a compare only affects jumps from the next step on.
    always_ff @(posedge clk) begin
        if (reset) begin
            fz  <= 1'b0;
            flt <= 1'b0;
        end else if (eo && !stall) begin
            fz  <= alu_z;
            flt <= alu_lt;
        end
    end

endmodule
